// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC/nPC pair (delayed-branch model), drives the instruction memory address and
// registers the returned word toward decode. Define FETCH_COUNT_EN to add the FetchCount advance counter.
module fetch_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP    = 32'd4
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] Address,
  input  logic [31:0] InstrIn,
  output logic [31:0] InstrOut,
  output logic [31:0] PCOut,
  output logic        InstrValid,
  input  logic        DecodeReady,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Halt,
  output logic        Halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0] FetchCount
`endif
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_HALTED
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] npc_q;
  logic [31:0] instr_q;
  logic [31:0] pcout_q;
  logic [31:0] target_q;
  logic        valid_q;
  logic        pend_q;
  logic        halt_q;
  logic        halted_q;
`ifdef FETCH_COUNT_EN
  logic [31:0] count_q;
`endif

  logic [31:0] branch_tgt;
  logic [31:0] npc_d;
  logic        halt_req;
  logic        slot_free;
  logic        advance;

  assign branch_tgt = BranchTarget & ~32'h3;

  // NOTE: the raw Halt input is folded in so a Halt arriving with a redirect stops fetch in that same cycle.
  assign halt_req  = halt_q | Halt;
  assign slot_free = ~valid_q | DecodeReady;
  assign advance   = (state_q == ST_RUN) & ~halt_req & slot_free;

  // A redirect arriving this cycle is newer than any latched pending target.
  always_comb begin
    npc_d = npc_q + PC_STEP;
    if (BranchTaken) begin
      npc_d = branch_tgt;
    end else if (pend_q) begin
      npc_d = target_q;
    end
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block and every register gets a value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_INIT;
      pc_q     <= RESET_ADDR;
      npc_q    <= RESET_ADDR + 32'd4;
      instr_q  <= '0;
      pcout_q  <= '0;
      target_q <= '0;
      valid_q  <= 1'b0;
      pend_q   <= 1'b0;
      halt_q   <= 1'b0;
      halted_q <= 1'b0;
`ifdef FETCH_COUNT_EN
      count_q  <= '0;
`endif
    end else begin
      if (Halt) begin
        halt_q <= 1'b1;
      end
      case (state_q)
        ST_INIT: begin
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (advance) begin
            instr_q <= InstrIn;
            pcout_q <= pc_q;
            valid_q <= 1'b1;
            pc_q    <= npc_q;
            npc_q   <= npc_d;
            pend_q  <= 1'b0;
`ifdef FETCH_COUNT_EN
            count_q <= count_q + 32'd1;
`endif
          end else if (halt_req) begin
            // Halt waits until decode has taken the word currently held.
            if (slot_free) begin
              state_q  <= ST_HALTED;
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
            end
          end else if (BranchTaken) begin
            pend_q   <= 1'b1;
            target_q <= branch_tgt;
          end
        end
        ST_HALTED: begin
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign Address    = pc_q;
  assign InstrOut   = instr_q;
  assign PCOut      = pcout_q;
  assign InstrValid = valid_q;
  assign Halted     = halted_q;
`ifdef FETCH_COUNT_EN
  assign FetchCount = count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected PCOut values are queued by each scenario and popped whenever
// decode accepts a word. A second instance with RESET_ADDR=FFFF_FFF8 covers address wrap-around.
module tb_fetch_sequencer;

  localparam logic [31:0] MEM_XOR = 32'hA5A5_0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Address, InstrIn, InstrOut, PCOut, BranchTarget;
  logic        InstrValid, DecodeReady, BranchTaken, Halt, Halted;
  logic [31:0] Address1, InstrIn1, InstrOut1, PCOut1;
  logic        InstrValid1, Halted1;
`ifdef FETCH_COUNT_EN
  logic [31:0] FetchCount, FetchCount1;
`endif

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 Clk = ~Clk;

  // Memory model: each word is its own address scrambled by a constant.
  assign InstrIn  = Address ^ MEM_XOR;
  assign InstrIn1 = Address1 ^ MEM_XOR;

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Address(Address), .InstrIn(InstrIn), .InstrOut(InstrOut), .PCOut(PCOut),
    .InstrValid(InstrValid), .DecodeReady(DecodeReady), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Halt(Halt), .Halted(Halted)
`ifdef FETCH_COUNT_EN
    , .FetchCount(FetchCount)
`endif
  );

  fetch_sequencer #(.RESET_ADDR(32'hFFFF_FFF8)) dut_wrap (
    .Clk(Clk), .Reset(Reset), .Address(Address1), .InstrIn(InstrIn1), .InstrOut(InstrOut1), .PCOut(PCOut1),
    .InstrValid(InstrValid1), .DecodeReady(1'b1), .BranchTaken(1'b0), .BranchTarget(32'h0), .Halt(1'b0),
    .Halted(Halted1)
`ifdef FETCH_COUNT_EN
    , .FetchCount(FetchCount1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a word is consumed on the edge following a negedge that sees valid & ready.
  always @(negedge Clk) begin
    if (!Reset && InstrValid && DecodeReady) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", PCOut, e);
        check("sb_instr", InstrOut, e ^ MEM_XOR);
        acc_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; DecodeReady = 1'b0; BranchTaken = 1'b0; BranchTarget = '0; Halt = 1'b0;
    tick();
    tick();
    @(negedge Clk);
    check("rst_valid", {31'd0, InstrValid}, 32'd0);
    check("rst_halted", {31'd0, Halted}, 32'd0);
    check("rst_addr", Address, 32'h0);
    check("rst_pcout", PCOut, 32'h0);
    check("rst_instr", InstrOut, 32'h0);
    tick();
    Reset = 1'b0;
  endtask

  // Hold DecodeReady high until n more words are accepted; drops it right after the last accepting edge.
  task automatic accept_n(input int n, output int ticks);
    int goal;
    tick();
    goal = acc_cnt + n;
    ticks = 0;
    DecodeReady = 1'b1;
    while (acc_cnt < goal && ticks < 40) begin
      tick();
      ticks++;
    end
    DecodeReady = 1'b0;
    check("accept_budget", 32'(acc_cnt), 32'(goal));
  endtask

  initial begin
    int t;

    // Basic stream, two-cycle latency, stall at PCOut=8 then gap-free resume.
    exp_q.push_back(32'd0); exp_q.push_back(32'd4); exp_q.push_back(32'd8);
    exp_q.push_back(32'd12); exp_q.push_back(32'd16);
    do_reset();
    DecodeReady = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check("lat_cycle1_valid", {31'd0, InstrValid}, 32'd0);
    @(negedge Clk);
    check("lat_cycle2_valid", {31'd0, InstrValid}, 32'd1);
    accept_n(1, t);
    repeat (3) begin
      @(negedge Clk);
      check("stall_pc", PCOut, 32'd8);
      check("stall_instr", InstrOut, 32'd8 ^ MEM_XOR);
      check("stall_addr", Address, 32'd12);
      check("stall_valid", {31'd0, InstrValid}, 32'd1);
    end
    accept_n(3, t);
    check("resume_nogap", 32'(t), 32'd3);
    check("drain_a", 32'(exp_q.size()), 32'd0);

    // Delayed branch: redirect on the edge that fetches 8; low target bits must be dropped.
    exp_q.push_back(32'd0); exp_q.push_back(32'd4); exp_q.push_back(32'd8);
    exp_q.push_back(32'd12); exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    do_reset();
    accept_n(1, t);
    DecodeReady = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h0000_0103;
    tick();
    BranchTaken = 1'b0; DecodeReady = 1'b0;
    accept_n(4, t);
    check("drain_branch", 32'(exp_q.size()), 32'd0);

    // Two redirects while stalled: the newer target wins after the delay slot.
    exp_q.push_back(32'd0); exp_q.push_back(32'd4); exp_q.push_back(32'd8);
    exp_q.push_back(32'd12); exp_q.push_back(32'h300); exp_q.push_back(32'h304);
    do_reset();
    accept_n(1, t);
    BranchTaken = 1'b1; BranchTarget = 32'h200;
    tick();
    BranchTarget = 32'h300;
    tick();
    BranchTaken = 1'b0;
    accept_n(5, t);
    check("drain_pending", 32'(exp_q.size()), 32'd0);

    // Halt while the output is stalled: word held until taken, then halted; redirects ignored.
    exp_q.push_back(32'd0); exp_q.push_back(32'd4);
    do_reset();
    accept_n(1, t);
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      check("halt_hold_valid", {31'd0, InstrValid}, 32'd1);
      check("halt_hold_pc", PCOut, 32'd4);
      check("halt_hold_halted", {31'd0, Halted}, 32'd0);
      tick();
    end
    DecodeReady = 1'b1;
    tick();
    DecodeReady = 1'b0;
    @(negedge Clk);
    check("halted_valid", {31'd0, InstrValid}, 32'd0);
    check("halted_flag", {31'd0, Halted}, 32'd1);
    check("halted_addr", Address, 32'd8);
    DecodeReady = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h400;
    repeat (3) tick();
    BranchTaken = 1'b0;
    @(negedge Clk);
    check("halted_br_valid", {31'd0, InstrValid}, 32'd0);
    check("halted_br_flag", {31'd0, Halted}, 32'd1);
    check("halted_br_addr", Address, 32'd8);
`ifdef FETCH_COUNT_EN
    check("fetch_count", FetchCount, 32'd2);
`endif
    DecodeReady = 1'b0;
    check("drain_halt", 32'(exp_q.size()), 32'd0);

    // Wrap-around instance, then reset asserted while the main instance is stalled.
    do_reset();
    @(posedge Clk);
    @(negedge Clk);
    check("wrap_lat_valid", {31'd0, InstrValid1}, 32'd0);
    @(negedge Clk);
    check("wrap_pc0", PCOut1, 32'hFFFF_FFF8);
    check("wrap_instr0", InstrOut1, 32'hFFFF_FFF8 ^ MEM_XOR);
    @(negedge Clk);
    check("wrap_pc1", PCOut1, 32'hFFFF_FFFC);
    @(negedge Clk);
    check("wrap_pc2", PCOut1, 32'h0000_0000);
    check("wrap_instr2", InstrOut1, MEM_XOR);
    check("stalled_before_rst", {31'd0, InstrValid}, 32'd1);
    tick();
    Reset = 1'b1;
    tick();
    @(negedge Clk);
    check("rst_mid_stall_valid", {31'd0, InstrValid}, 32'd0);
    check("rst_mid_stall_addr", Address, 32'd0);
    Reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
